reg_file: RTL

Parametrised multi-register bank that generalises the single 32-bit bus register into a register file with two registered read ports, one byte-maskable write port, optional write-to-read bypass, an optional hardwired-zero R0, and a per-register busy scoreboard. It sits between the datapath bus and the ALU operand latches. The pipeline control logic uses it for hazard detection through the busy bits.

---
 rtl/reg_file_pkg.sv | 29 ++
 rtl/reg_file_if.sv | 39 +++
 rtl/reg_file_port.sv | 44 ++++
 rtl/reg_file.sv | 62 ++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file: address sizing, byte
// counting and the byte-lane merge used by storage writes and the bypass.
package reg_file_pkg;

  localparam int BYTE_W = 8;
  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_W  = 256;
  localparam int MAX_NB = MAX_W / BYTE_W;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int bytes_per_word(input int width);
    return width / BYTE_W;
  endfunction

  function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0]  old_word,
                                             input logic [MAX_W-1:0]  new_word,
                                             input logic [MAX_NB-1:0] byte_en);
    logic [MAX_W-1:0] result;
    result = old_word;
    for (int i = 0; i < MAX_NB; i++) begin
      if (byte_en[i]) result[BYTE_W*i +: BYTE_W] = new_word[BYTE_W*i +: BYTE_W];
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bus-side signals of the register file.
// All enables are single-cycle strobes with no ready/backpressure: the file
// always accepts write_en, read_en and reserve_en on the rising edge they are
// sampled high, and Qa/Qb hold their value until the next read_en.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = addr_width(DEPTH);
  localparam int NB = bytes_per_word(WIDTH);

  logic             write_en;
  logic [AW-1:0]    write_addr;
  logic [NB-1:0]    byte_en;
  logic [WIDTH-1:0] D;
  logic             read_en;
  logic [AW-1:0]    read_addr_a;
  logic [AW-1:0]    read_addr_b;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;
  logic             reserve_en;
  logic [AW-1:0]    reserve_addr;
  logic             busy_a;
  logic             busy_b;

  modport master (
    output write_en, write_addr, byte_en, D, read_en, read_addr_a, read_addr_b,
           reserve_en, reserve_addr,
    input  Qa, Qb, busy_a, busy_b
  );

  modport slave (
    input  write_en, write_addr, byte_en, D, read_en, read_addr_a, read_addr_b,
           reserve_en, reserve_addr,
    output Qa, Qb, busy_a, busy_b
  );
endinterface

// File: rtl/reg_file_port.sv
// One registered read port: storage mux, optional write forwarding and
// R0 masking in front of the output register.
module reg_file_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = addr_width(DEPTH),
  localparam int NB      = bytes_per_word(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             read_en,
  input  logic [AW-1:0]    read_addr,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [NB-1:0]    byte_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stored;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] next_q;

  always_comb begin
    stored = regs[read_addr];
    merged = WIDTH'(merge(MAX_W'(stored), MAX_W'(d), MAX_NB'(byte_en)));
    next_q = stored;
    if (BYPASS != 0 && write_en && write_addr == read_addr) next_q = merged;
    // Masking after the bypass keeps R0 at zero even when a write targets it.
    if (ZERO_REG != 0 && read_addr == '0) next_q = '0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= '0;
    end else if (read_en) begin
      q <= next_q;
    end
  end
endmodule

// File: rtl/reg_file.sv
// Register file with two registered read ports, a byte-masked write port
// and a per-register busy scoreboard for hazard detection.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 16,
  parameter int               ZERO_REG    = 1,
  parameter int               BYPASS      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic       clock,
  input logic       clear,
  reg_file_if.slave bus
);
  localparam int AW = addr_width(DEPTH);
  localparam int NB = bytes_per_word(WIDTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             store_en;
  logic [WIDTH-1:0] write_word;

  assign store_en   = bus.write_en && !(ZERO_REG != 0 && bus.write_addr == '0);
  assign write_word = WIDTH'(merge(MAX_W'(regs[bus.write_addr]), MAX_W'(bus.D),
                                   MAX_NB'(bus.byte_en)));

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RESET_VALUE;
      end
      busy <= '0;
    end else begin
      if (store_en) regs[bus.write_addr] <= write_word;
      // Later assignments win: a same-cycle reserve re-claims a register the
      // write is releasing, and R0 never shows as busy.
      if (bus.write_en)   busy[bus.write_addr]   <= 1'b0;
      if (bus.reserve_en) busy[bus.reserve_addr] <= 1'b1;
      if (ZERO_REG != 0)  busy[0]                <= 1'b0;
    end
  end

  assign bus.busy_a = busy[bus.read_addr_a];
  assign bus.busy_b = busy[bus.read_addr_b];

  reg_file_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_a (
    .clock(clock), .clear(clear), .read_en(bus.read_en),
    .read_addr(bus.read_addr_a), .regs(regs), .write_en(store_en),
    .write_addr(bus.write_addr), .byte_en(bus.byte_en), .d(bus.D), .q(bus.Qa)
  );

  reg_file_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_b (
    .clock(clock), .clear(clear), .read_en(bus.read_en),
    .read_addr(bus.read_addr_b), .regs(regs), .write_en(store_en),
    .write_addr(bus.write_addr), .byte_en(bus.byte_en), .d(bus.D), .q(bus.Qb)
  );
endmodule
